// File: rtl/pcileech_pcie_bar_rsp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pcileech_pcie_bar_rsp                                                      |
// | Single-BAR memory responder: services 1-DW MRd/MWr from a DWORD array and  |
// | queues CplD completions in the packed 2x66-bit TX mux format.              |
// | Optional: BAR_RSP_UR_EN (Unsupported Request completion for bad MRd).      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pcileech_pcie_bar_rsp #(
   parameter int ADDR_W    = 10,
   parameter int BAR_INDEX = 0,
   parameter int CPL_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       tlp_pcie_id,
   input  logic [63:0]       rx_data,
   input  logic [7:0]        rx_keep,
   input  logic              rx_last,
   input  logic              rx_valid,
   input  logic [6:0]        rx_bar_hit,
   input  logic              usr_wr_en,
   input  logic [ADDR_W-1:0] usr_addr,
   input  logic [31:0]       usr_data,
   input  logic              cpl_req_data,
   output logic              cpl_has_data,
   output logic              cpl_valid,
   output logic [131:0]      cpl_data,
   output logic [15:0]       drop_cnt
);

   localparam int c_DEPTH = 2**ADDR_W;
   localparam int c_PTR_W = $clog2(CPL_DEPTH);
   localparam int c_CNT_W = $clog2(CPL_DEPTH + 1);
   localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(CPL_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HDR2 = 2'd1,
      S_DAT4 = 2'd2,
      S_SKIP = 2'd3
   } state_t;

   state_t r_state, w_state_nxt;

   // First-beat decode (DW0 in rx_data[31:0])
   logic w_bar, w_type_ok, w_shape_ok, w_hdr_ok, w_ur_req;
   assign w_bar      = rx_bar_hit[BAR_INDEX];
   assign w_type_ok  = (rx_data[31] == 1'b0) && (rx_data[28:24] == 5'd0);
   assign w_shape_ok = (rx_data[9:0] == 10'd1) && (rx_data[22:20] == 3'd0);
   assign w_hdr_ok   = w_bar && w_type_ok && w_shape_ok;
`ifdef BAR_RSP_UR_EN
   assign w_ur_req   = w_bar && w_type_ok && !rx_data[30] && !w_shape_ok;
`else
   assign w_ur_req   = 1'b0;
`endif

   logic              r_is_wr, r_is_4dw, r_ur;
   logic [15:0]       r_req_id;
   logic [7:0]        r_tag;
   logic [3:0]        r_fbe;
   logic [ADDR_W-1:0] r_idx;
   logic [4:0]        r_addr5;

   // Second-beat decode: address lives in DW2 (3DW) or DW3 (4DW)
   logic [31:0] w_addr;
   logic [7:0]  w_exp_keep;
   logic        w_want_last, w_hdr2_ok;
   logic        w_unused;
   assign w_addr      = r_is_4dw ? rx_data[63:32] : rx_data[31:0];
   assign w_exp_keep  = (r_is_4dw || r_is_wr) ? 8'hff : 8'h0f;
   assign w_want_last = !(r_is_wr && r_is_4dw);
   assign w_hdr2_ok   = (rx_keep == w_exp_keep) && (rx_last == w_want_last);
   assign w_unused    = ^{w_addr[31:ADDR_W+2], w_addr[1:0]};

   logic              w_commit_wr, w_commit_rd;
   logic [ADDR_W-1:0] w_commit_idx;
   logic [4:0]        w_commit_addr5;
   logic [31:0]       w_commit_wdata;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_commit_wr    = 1'b0;
      w_commit_rd    = 1'b0;
      w_commit_idx   = r_idx;
      w_commit_addr5 = r_addr5;
      w_commit_wdata = rx_data[31:0];
      case (r_state)
         S_IDLE: begin
            if (rx_valid && !rx_last)
               w_state_nxt = (w_hdr_ok || w_ur_req) ? S_HDR2 : S_SKIP;
         end
         S_HDR2: begin
            w_commit_idx   = w_addr[ADDR_W+1:2];
            w_commit_addr5 = w_addr[6:2];
            w_commit_wdata = rx_data[63:32];
            if (rx_valid) begin
               if (w_hdr2_ok && w_want_last) begin
                  w_commit_wr = r_is_wr;
                  w_commit_rd = !r_is_wr;
                  w_state_nxt = S_IDLE;
               end else if (w_hdr2_ok) begin
                  w_state_nxt = S_DAT4;
               end else begin
                  w_state_nxt = rx_last ? S_IDLE : S_SKIP;
               end
            end
         end
         S_DAT4: begin
            if (rx_valid) begin
               if (rx_last && rx_keep == 8'h0f) begin
                  w_commit_wr = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_state_nxt = rx_last ? S_IDLE : S_SKIP;
               end
            end
         end
         S_SKIP: begin
            if (rx_valid && rx_last) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (rst) begin
         w_commit_wr = 1'b0;
         w_commit_rd = 1'b0;
      end
   end

   // Header fields are only consumed when the FSM advances past them
   always_ff @(posedge clk) begin
      if (r_state == S_IDLE && rx_valid) begin
         r_is_wr  <= rx_data[30];
         r_is_4dw <= rx_data[29];
         r_ur     <= !w_hdr_ok;
         r_req_id <= rx_data[63:48];
         r_tag    <= rx_data[47:40];
         r_fbe    <= rx_data[35:32];
      end
      if (r_state == S_HDR2 && rx_valid) begin
         r_idx   <= w_addr[ADDR_W+1:2];
         r_addr5 <= w_addr[6:2];
      end
   end

   // TLP write is issued after the user write so it wins on shared bytes
   logic [31:0] r_mem [c_DEPTH];
   logic [31:0] r_rd_data;
   always_ff @(posedge clk) begin
      if (usr_wr_en) r_mem[usr_addr] <= usr_data;
      if (w_commit_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (r_fbe[b]) r_mem[w_commit_idx][8*b +: 8] <= w_commit_wdata[8*b +: 8];
         end
      end
      if (w_commit_rd) r_rd_data <= r_mem[w_commit_idx];
   end

   logic        r_pend, r_p_ur;
   logic [15:0] r_p_req_id;
   logic [7:0]  r_p_tag;
   logic [4:0]  r_p_addr5;
   always_ff @(posedge clk) begin
      if (rst) r_pend <= 1'b0;
      else     r_pend <= w_commit_rd;
      if (w_commit_rd) begin
         r_p_req_id <= r_req_id;
         r_p_tag    <= r_tag;
         r_p_addr5  <= w_commit_addr5;
         r_p_ur     <= r_ur;
      end
   end

   logic [63:0]  w_qw1, w_qw2;
   logic [131:0] w_push_word;
   assign w_qw1 = r_p_ur ? {tlp_pcie_id, 16'h2000, 32'h0A000000}
                         : {tlp_pcie_id, 16'h0004, 32'h4A000001};
   assign w_qw2 = r_p_ur ? {32'h0, r_p_req_id, r_p_tag, 8'h00}
                         : {r_rd_data, r_p_req_id, r_p_tag, 1'b0, r_p_addr5, 2'b00};
   assign w_push_word = {!r_p_ur, 1'b1, w_qw2, 2'b10, w_qw1};

   logic [131:0]       r_q [CPL_DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr, r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;
   logic               r_has_q;
   logic               w_pop, w_push, w_drop;

   // A pop in the same cycle frees the slot a push on a full queue needs
   assign w_pop  = cpl_req_data && (r_count != '0);
   assign w_push = r_pend && ((r_count != c_FULL) || w_pop);
   assign w_drop = r_pend && !w_push;
   assign cpl_has_data = r_has_q && (r_count != '0);

   always_ff @(posedge clk) begin
      if (w_push) r_q[r_wr_ptr] <= w_push_word;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_has_q   <= 1'b0;
         cpl_valid <= 1'b0;
         cpl_data  <= '0;
         drop_cnt  <= '0;
      end else begin
         r_has_q   <= (r_count != '0);
         cpl_valid <= w_pop;
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            cpl_data <= r_q[r_rd_ptr];
         end
         if (w_push && !w_pop)      r_count <= r_count + c_CNT_W'(1);
         else if (!w_push && w_pop) r_count <= r_count - c_CNT_W'(1);
         if (w_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
   end

endmodule
`default_nettype wire
